rdma_rx_frame_fifo: RTL

Store-and-forward receive frame buffer between the Ethernet MAC RX stream and the RDMA IP/UDP decapsulator input. Accepts 32-bit AXI-Stream frames and holds each one until its last beat arrives. Forwards only complete, error-free frames that fit. Frames flagged bad by the MAC (tuser), oversized frames and frames hitting buffer overflow are discarded whole, so the decapsulator never sees a partial or corrupt frame.

---
 rtl/rdma_rx_frame_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rdma_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: forwards only complete, clean frames that fit (stats behind RX_FIFO_STATS_EN).
// Latency: tlast accepted at edge T -> m_axis_tvalid high from edge T+2 on an empty buffer, then 1 beat/cycle.
// Backpressure: MAC is never stalled; bad/oversize/overflowing frames are dropped whole, m_axis obeys tready.
module rdma_rx_frame_fifo #(
    parameter int DEPTH_LOG2      = 9,
    parameter int MAX_FRAME_WORDS = 380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axis_tdata,
    input  logic [3:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic [3:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic [DEPTH_LOG2:0]   o_fill_words,
    output logic                  o_frame_drop,
    input  logic                  i_stat_clear,
    output logic [31:0]           o_stat_frames_ok,
    output logic [31:0]           o_stat_drop_err,
    output logic [31:0]           o_stat_drop_ovf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(MAX_FRAME_WORDS + 1);

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic {ST_ACCEPT, ST_DISCARD} wr_state_t;

    logic [36:0]      mem_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             commit_ptr_q, commit_ptr_d;
    ptr_t             commit_vis_q;
    ptr_t             rd_ptr_q, rd_ptr_d;
    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             bad_q, bad_d;
    logic             drop_q, drop_d;
    logic             wr_en;
    logic             ev_ok, ev_err, ev_ovf;
    ptr_t             used;
    logic             full;

    // Read side state: rd_ptr_q indexes the word held in the output register while it is valid.
    logic             m_vld_q, m_vld_d;
    logic [36:0]      m_word_q, m_word_d;
    logic             pop;
    ptr_t             load_ptr;
    logic             avail;

    assign used          = wr_ptr_q - rd_ptr_q;
    assign full          = (used == ptr_t'(DEPTH));
    assign s_axis_tready = ~rst;

    // Write FSM: speculative writes, commit on a clean tlast, rewind to commit_ptr on any drop.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        bad_d        = bad_q;
        wr_en        = 1'b0;
        drop_d       = 1'b0;
        ev_ok        = 1'b0;
        ev_err       = 1'b0;
        ev_ovf       = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (s_axis_tvalid) begin
                    if (full || (beat_cnt_q == CNT_W'(MAX_FRAME_WORDS))) begin
                        // Overflow takes precedence when both apply; the beat itself is not stored.
                        wr_ptr_d   = commit_ptr_q;
                        drop_d     = 1'b1;
                        ev_ovf     = full;
                        ev_err     = ~full;
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                        if (!s_axis_tlast) state_d = ST_DISCARD;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                        if (s_axis_tlast) begin
                            beat_cnt_d = '0;
                            bad_d      = 1'b0;
                            if (bad_q || s_axis_tuser) begin
                                wr_ptr_d = commit_ptr_q;
                                drop_d   = 1'b1;
                                ev_err   = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + ptr_t'(1);
                                ev_ok        = 1'b1;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                            bad_d      = bad_q | s_axis_tuser;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d    = ST_ACCEPT;
                    beat_cnt_d = '0;
                    bad_d      = 1'b0;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Write-side registers; reset discards everything including committed frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            commit_vis_q <= '0;
            beat_cnt_q   <= '0;
            bad_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            commit_vis_q <= commit_ptr_q;
            beat_cnt_q   <= beat_cnt_d;
            bad_q        <= bad_d;
            drop_q       <= drop_d;
        end
    end

    // Frame storage; every accepted beat lands at the speculative write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    end

    // The reader sees commits one cycle late, so a same-cycle commit is never raced.
    assign pop      = m_vld_q & m_axis_tready;
    assign load_ptr = pop ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
    assign avail    = (load_ptr != commit_vis_q);

    // FWFT output stage: refill when empty or when the held beat is taken, otherwise hold.
    always_comb begin
        rd_ptr_d = load_ptr;
        m_vld_d  = m_vld_q;
        m_word_d = m_word_q;
        if (!m_vld_q || pop) begin
            m_vld_d = avail;
            if (avail) m_word_d = mem_q[load_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Output register and read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            m_vld_q  <= 1'b0;
            m_word_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            m_vld_q  <= m_vld_d;
            m_word_q <= m_word_d;
        end
    end

    assign m_axis_tdata  = m_word_q[36:5];
    assign m_axis_tkeep  = m_word_q[4:1];
    assign m_axis_tlast  = m_word_q[0];
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tuser  = 1'b0;
    assign o_fill_words  = commit_ptr_q - rd_ptr_q;
    assign o_frame_drop  = drop_q;

`ifdef RX_FIFO_STATS_EN
    logic [31:0] st_ok_q, st_err_q, st_ovf_q;

    // Event counters, wrapping; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || i_stat_clear) begin
            st_ok_q  <= '0;
            st_err_q <= '0;
            st_ovf_q <= '0;
        end else begin
            if (ev_ok)  st_ok_q  <= st_ok_q + 32'd1;
            if (ev_err) st_err_q <= st_err_q + 32'd1;
            if (ev_ovf) st_ovf_q <= st_ovf_q + 32'd1;
        end
    end

    assign o_stat_frames_ok = st_ok_q;
    assign o_stat_drop_err  = st_err_q;
    assign o_stat_drop_ovf  = st_ovf_q;
`else
    logic stats_unused;
    assign stats_unused     = ^{i_stat_clear, ev_ok, ev_err, ev_ovf};
    assign o_stat_frames_ok = '0;
    assign o_stat_drop_err  = '0;
    assign o_stat_drop_ovf  = '0;
`endif

endmodule
